// File: rtl/axi4_config_master.sv
// Single-outstanding AXI4 initiator: one command becomes one AW/W+B or AR+R beat and then one response.
// AXI valids are registered one cycle after the command handshake. A new command waits until rsp is consumed. Optional error counter: AXI4_CFG_MST_ERR_CNT_EN.
module axi4_config_master #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned MST_ID_W     = 5,
   parameter int unsigned MST_ID       = 0,
   parameter int unsigned TRANS_RESP_W = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid_i,
   input  logic                    cmd_wr_i,
   input  logic [ADDR_W-1:0]       cmd_addr_i,
   input  logic [DATA_W-1:0]       cmd_wdata_i,
   output logic                    cmd_ready_o,
   output logic                    rsp_valid_o,
   output logic                    rsp_wr_o,
   output logic [DATA_W-1:0]       rsp_rdata_o,
   output logic [TRANS_RESP_W-1:0] rsp_resp_o,
   input  logic                    rsp_ready_i,
   output logic [MST_ID_W-1:0]     m_awid_o,
   output logic [ADDR_W-1:0]       m_awaddr_o,
   output logic                    m_awvalid_o,
   input  logic                    m_awready_i,
   output logic [DATA_W-1:0]       m_wdata_o,
   output logic                    m_wvalid_o,
   input  logic                    m_wready_i,
   input  logic [MST_ID_W-1:0]     m_bid_i,
   input  logic [TRANS_RESP_W-1:0] m_bresp_i,
   input  logic                    m_bvalid_i,
   output logic                    m_bready_o,
   output logic [MST_ID_W-1:0]     m_arid_o,
   output logic [ADDR_W-1:0]       m_araddr_o,
   output logic                    m_arvalid_o,
   input  logic                    m_arready_i,
   input  logic [MST_ID_W-1:0]     m_rid_i,
   input  logic [DATA_W-1:0]       m_rdata_i,
   input  logic [TRANS_RESP_W-1:0] m_rresp_i,
   input  logic                    m_rvalid_i,
`ifdef AXI4_CFG_MST_ERR_CNT_EN
   input  logic                    err_cnt_clr_i,
   output logic [7:0]              err_cnt_o,
`endif
   output logic                    m_rready_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_REQ = 3'd1,
      WR_RSP = 3'd2,
      RD_REQ = 3'd3,
      RD_RSP = 3'd4,
      RESP   = 3'd5
   } state_t;

   localparam logic [MST_ID_W-1:0]     ID_V      = MST_ID_W'(MST_ID);
   localparam logic [TRANS_RESP_W-1:0] RESP_SLVE = TRANS_RESP_W'(2);

   state_t                  state_q, state_d;
   logic                    wr_q, wr_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    arvalid_q, arvalid_d;
   logic                    bready_q, bready_d;
   logic                    rready_q, rready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic [TRANS_RESP_W-1:0] rsp_resp_q, rsp_resp_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign aw_hs = awvalid_q & m_awready_i;
   assign w_hs  = wvalid_q  & m_wready_i;
   assign b_hs  = bready_q  & m_bvalid_i;
   assign ar_hs = arvalid_q & m_arready_i;
   assign r_hs  = rready_q  & m_rvalid_i;

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               wr_d    = cmd_wr_i;
               addr_d  = cmd_addr_i;
               wdata_d = cmd_wdata_i;
               if (cmd_wr_i) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            // A channel whose valid is already low finished its handshake earlier.
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
               bready_d = 1'b1;
               state_d  = WR_RSP;
            end
         end
         WR_RSP: begin
            if (b_hs) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_resp_d  = (m_bid_i == ID_V) ? m_bresp_i : RESP_SLVE;
               state_d     = RESP;
            end
         end
         RD_REQ: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_RSP;
            end
         end
         RD_RSP: begin
            if (r_hs) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = m_rdata_i;
               rsp_resp_d  = (m_rid_i == ID_V) ? m_rresp_i : RESP_SLVE;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign cmd_ready_o = (state_q == IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_wr_o    = wr_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_resp_o  = rsp_resp_q;
   assign m_awid_o    = ID_V;
   assign m_awaddr_o  = addr_q;
   assign m_awvalid_o = awvalid_q;
   assign m_wdata_o   = wdata_q;
   assign m_wvalid_o  = wvalid_q;
   assign m_bready_o  = bready_q;
   assign m_arid_o    = ID_V;
   assign m_araddr_o  = addr_q;
   assign m_arvalid_o = arvalid_q;
   assign m_rready_o  = rready_q;

`ifdef AXI4_CFG_MST_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Clear beats a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_cnt_clr_i) begin
         err_cnt_d = '0;
      end else if (rsp_valid_q && rsp_ready_i && (rsp_resp_q != '0) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi4_config_master.sv
// Randomized bench for axi4_config_master: a reference model queues the expected responses, and a monitor checks the responses and the AXI protocol.
module tb_axi4_config_master;
   localparam int unsigned MID = 6;
   localparam logic [4:0] MID_V = 5'(MID);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid_i = 1'b0, cmd_wr_i = 1'b0;
   logic [31:0] cmd_addr_i = '0;
   logic [7:0]  cmd_wdata_i = '0;
   logic        cmd_ready_o, rsp_valid_o, rsp_wr_o;
   logic [7:0]  rsp_rdata_o;
   logic [1:0]  rsp_resp_o;
   logic        rsp_ready_i = 1'b0;
   logic [4:0]  m_awid_o, m_arid_o;
   logic [31:0] m_awaddr_o, m_araddr_o;
   logic        m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o;
   logic [7:0]  m_wdata_o;
   logic        m_awready_i = 1'b0, m_wready_i = 1'b0, m_arready_i = 1'b0;
   logic [4:0]  m_bid_i = '0, m_rid_i = '0;
   logic [1:0]  m_bresp_i = '0, m_rresp_i = '0;
   logic        m_bvalid_i = 1'b0, m_rvalid_i = 1'b0;
   logic [7:0]  m_rdata_i = '0;
`ifdef AXI4_CFG_MST_ERR_CNT_EN
   logic        err_cnt_clr_i = 1'b0;
   logic [7:0]  err_cnt_o;
`endif

   always #5 clk = ~clk;

   axi4_config_master #(.MST_ID(MID)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid_i), .cmd_wr_i(cmd_wr_i), .cmd_addr_i(cmd_addr_i),
      .cmd_wdata_i(cmd_wdata_i), .cmd_ready_o(cmd_ready_o),
      .rsp_valid_o(rsp_valid_o), .rsp_wr_o(rsp_wr_o), .rsp_rdata_o(rsp_rdata_o),
      .rsp_resp_o(rsp_resp_o), .rsp_ready_i(rsp_ready_i),
      .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o),
      .m_awready_i(m_awready_i), .m_wdata_o(m_wdata_o), .m_wvalid_o(m_wvalid_o),
      .m_wready_i(m_wready_i), .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i),
      .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
      .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o),
      .m_arready_i(m_arready_i), .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i),
      .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i),
`ifdef AXI4_CFG_MST_ERR_CNT_EN
      .err_cnt_clr_i(err_cnt_clr_i), .err_cnt_o(err_cnt_o),
`endif
      .m_rready_o(m_rready_o)
   );

   typedef struct { logic wr; logic [31:0] addr; logic [7:0] data; } req_t;
   typedef struct { logic wr; logic [7:0] rdata; logic [1:0] resp; int aw_cyc; int w_cyc; int ar_cyc; } exp_t;
   typedef struct { logic [1:0] resp; logic bad_id; int aw_dly; int w_dly; int ar_dly; int b_dly; } plan_t;

   req_t  req_q[$];
   exp_t  exp_q[$];
   plan_t plan_q[$];
   logic [7:0] ref_mem [logic [31:0]];
   logic [7:0] slv_mem [logic [31:0]];
   int checks = 0;
   int failures = 0;
   int rdy_mode = 0;  // 0 random, 1 held low, 2 held high

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   function automatic plan_t mk_plan(input logic [1:0] resp, input logic bad_id,
                                     input int awd, input int wd, input int ard, input int bd);
      plan_t p;
      p.resp = resp; p.bad_id = bad_id; p.aw_dly = awd; p.w_dly = wd; p.ar_dly = ard; p.b_dly = bd;
      return p;
   endfunction

   // Reference: writes land in memory, reads return the last write, and a foreign ID turns into SLVERR.
   task automatic push_txn(input logic wr, input logic [31:0] addr, input logic [7:0] data, input plan_t p);
      req_t r;
      exp_t e;
      r.wr = wr; r.addr = addr; r.data = data;
      e.wr = wr;
      e.rdata = wr ? 8'h00 : (ref_mem.exists(addr) ? ref_mem[addr] : 8'h00);
      e.resp = p.bad_id ? 2'b10 : p.resp;
      e.aw_cyc = wr ? p.aw_dly + 1 : 0;
      e.w_cyc = wr ? p.w_dly + 1 : 0;
      e.ar_cyc = wr ? 0 : p.ar_dly + 1;
      if (wr) ref_mem[addr] = data;
      req_q.push_back(r);
      exp_q.push_back(e);
      plan_q.push_back(p);
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] data, input plan_t p);
      bit got;
      push_txn(wr, addr, data, p);
      @(posedge clk); #1;
      cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_addr_i = addr; cmd_wdata_i = data;
      got = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cmd_ready_o) begin got = 1; break; end
      end
      if (!got) timeout("cmd_accept");
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic drain();
      bit got;
      got = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin got = 1; break; end
      end
      if (!got) timeout("drain");
      @(posedge clk); #1;
   endtask

   initial begin : rsp_ready_drv
      forever begin
         @(posedge clk); #2;
         case (rdy_mode)
            0:       rsp_ready_i = ($urandom_range(0, 3) != 0);
            1:       rsp_ready_i = 1'b0;
            default: rsp_ready_i = 1'b1;
         endcase
      end
   end

   // AXI slave: executes the pre-chosen plan of each transaction against its own memory.
   initial begin : slave
      plan_t p;
      logic active, is_wr, aw_done, w_done, ar_done, wrote;
      logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
      logic [31:0] a_w, a_r;
      logic [7:0] d_w;
      int aw_cnt, w_cnt, ar_cnt, b_cnt;
      active = 0; is_wr = 0; aw_done = 0; w_done = 0; ar_done = 0; wrote = 0;
      a_w = '0; a_r = '0; d_w = '0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0;
      p = mk_plan(2'b00, 1'b0, 0, 0, 0, 0);
      forever begin
         @(negedge clk);
         aw_hs = m_awvalid_o & m_awready_i;
         w_hs  = m_wvalid_o & m_wready_i;
         b_hs  = m_bvalid_i & m_bready_o;
         ar_hs = m_arvalid_o & m_arready_i;
         r_hs  = m_rvalid_i & m_rready_o;
         if (aw_hs) a_w = m_awaddr_o;
         if (w_hs)  d_w = m_wdata_o;
         if (ar_hs) a_r = m_araddr_o;
         @(posedge clk); #1;
         if (!rst_n) begin
            active = 0;
            m_awready_i = 0; m_wready_i = 0; m_arready_i = 0; m_bvalid_i = 0; m_rvalid_i = 0;
            continue;
         end
         if (aw_hs) begin aw_done = 1; m_awready_i = 0; end
         if (w_hs)  begin w_done = 1;  m_wready_i = 0;  end
         if (ar_hs) begin ar_done = 1; m_arready_i = 0; end
         if (b_hs || r_hs) begin m_bvalid_i = 0; m_rvalid_i = 0; active = 0; end
         if (!active && (m_awvalid_o || m_arvalid_o) && plan_q.size() > 0) begin
            p = plan_q.pop_front();
            active = 1; is_wr = m_awvalid_o;
            aw_done = 0; w_done = 0; ar_done = 0; wrote = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0;
         end
         if (active && is_wr) begin
            if (!aw_done) begin m_awready_i = (aw_cnt >= p.aw_dly); aw_cnt++; end
            if (!w_done)  begin m_wready_i = (w_cnt >= p.w_dly); w_cnt++; end
            if (aw_done && w_done && !wrote) begin slv_mem[a_w] = d_w; wrote = 1; end
            if (aw_done && w_done && !m_bvalid_i) begin
               if (b_cnt >= p.b_dly) begin
                  m_bvalid_i = 1; m_bresp_i = p.resp;
                  m_bid_i = p.bad_id ? (MID_V ^ 5'h07) : MID_V;
               end else b_cnt++;
            end
         end
         if (active && !is_wr) begin
            if (!ar_done) begin
               m_arready_i = (ar_cnt >= p.ar_dly); ar_cnt++;
            end else if (!m_rvalid_i) begin
               if (b_cnt >= p.b_dly) begin
                  m_rvalid_i = 1; m_rresp_i = p.resp;
                  m_rid_i = p.bad_id ? (MID_V ^ 5'h07) : MID_V;
                  m_rdata_i = slv_mem.exists(a_r) ? slv_mem[a_r] : 8'h00;
               end else b_cnt++;
            end
         end
      end
   end

   initial begin : monitor
      req_t cur;
      exp_t e;
      logic p_aw, p_w, p_rsp;
      logic [31:0] p_awaddr;
      logic [7:0] p_wdata;
      logic [10:0] p_rsp_dat;
      int aw_n, w_n, ar_n, aw_c, w_c, ar_c, err_model;
      cur.wr = 0; cur.addr = '0; cur.data = '0;
      p_aw = 0; p_w = 0; p_rsp = 0; p_awaddr = '0; p_wdata = '0; p_rsp_dat = '0;
      aw_n = 0; w_n = 0; ar_n = 0; aw_c = 0; w_c = 0; ar_c = 0; err_model = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_aw = 0; p_w = 0; p_rsp = 0; err_model = 0;
            aw_n = 0; w_n = 0; ar_n = 0; aw_c = 0; w_c = 0; ar_c = 0;
            continue;
         end
         if (p_aw) begin
            chk("aw_hold", m_awvalid_o, 1'b1);
            chk("aw_stable", m_awaddr_o, p_awaddr);
         end
         if (p_w) begin
            chk("w_hold", m_wvalid_o, 1'b1);
            chk("w_stable", m_wdata_o, p_wdata);
         end
         if (m_awvalid_o || m_arvalid_o) chk("aw_ar_excl", m_awvalid_o & m_arvalid_o, 1'b0);
         if (m_awvalid_o) aw_c++;
         if (m_wvalid_o)  w_c++;
         if (m_arvalid_o) ar_c++;
         if (m_awvalid_o && m_awready_i) begin
            aw_n++;
            chk("awaddr", m_awaddr_o, cur.addr);
            chk("awid", m_awid_o, MID_V);
         end
         if (m_wvalid_o && m_wready_i) begin
            w_n++;
            chk("wdata", m_wdata_o, cur.data);
         end
         if (m_arvalid_o && m_arready_i) begin
            ar_n++;
            chk("araddr", m_araddr_o, cur.addr);
            chk("arid", m_arid_o, MID_V);
         end
         if (p_rsp) chk("rsp_stable", {rsp_valid_o, rsp_wr_o, rsp_rdata_o, rsp_resp_o}, {1'b1, p_rsp_dat});
         if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected actual=rsp_valid required=none");
            end else begin
               e = exp_q.pop_front();
               chk("rsp_wr", rsp_wr_o, e.wr);
               chk("rsp_rdata", rsp_rdata_o, e.rdata);
               chk("rsp_resp", rsp_resp_o, e.resp);
               chk("aw_beats", aw_n, e.wr ? 1 : 0);
               chk("w_beats", w_n, e.wr ? 1 : 0);
               chk("ar_beats", ar_n, e.wr ? 0 : 1);
               chk("aw_valid_cycles", aw_c, e.aw_cyc);
               chk("w_valid_cycles", w_c, e.w_cyc);
               chk("ar_valid_cycles", ar_c, e.ar_cyc);
`ifdef AXI4_CFG_MST_ERR_CNT_EN
               chk("err_cnt", err_cnt_o, err_model);
               if (e.resp != 2'b00 && err_model < 255) err_model++;
`endif
            end
         end
         if (cmd_valid_i && cmd_ready_o) begin
            if (req_q.size() > 0) cur = req_q.pop_front();
            aw_n = 0; w_n = 0; ar_n = 0; aw_c = 0; w_c = 0; ar_c = 0;
         end
         p_aw = m_awvalid_o & ~m_awready_i;
         p_awaddr = m_awaddr_o;
         p_w = m_wvalid_o & ~m_wready_i;
         p_wdata = m_wdata_o;
         p_rsp = rsp_valid_o & ~rsp_ready_i;
         p_rsp_dat = {rsp_wr_o, rsp_rdata_o, rsp_resp_o};
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit got;
      ref_mem[32'h3000_000A] = 8'h01;
      slv_mem[32'h3000_000A] = 8'h01;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cmd_ready", cmd_ready_o, 1'b1);
      chk("reset_valids", {m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o, rsp_valid_o}, 6'b0);
      chk("reset_payload", {rsp_rdata_o, rsp_resp_o, m_awaddr_o, m_wdata_o}, 50'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed scenarios.
      issue(1'b1, 32'h3000_0005, 8'h2C, mk_plan(2'b00, 1'b0, 0, 0, 0, 0));
      issue(1'b1, 32'h3000_0006, 8'h77, mk_plan(2'b00, 1'b0, 3, 0, 0, 0));
      issue(1'b0, 32'h3000_000A, 8'h00, mk_plan(2'b00, 1'b0, 0, 0, 0, 0));
      issue(1'b1, 32'h3000_0020, 8'h99, mk_plan(2'b11, 1'b0, 0, 0, 0, 1));
      issue(1'b0, 32'h3000_0005, 8'h00, mk_plan(2'b00, 1'b1, 0, 0, 2, 0));
      drain();
`ifdef AXI4_CFG_MST_ERR_CNT_EN
      chk("err_cnt_after_errors", err_cnt_o, 8'd2);
`endif

      // Response backpressure blocks the next command.
      rdy_mode = 1;
      issue(1'b1, 32'h3000_0007, 8'h3C, mk_plan(2'b00, 1'b0, 1, 2, 0, 0));
      got = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid_o) begin got = 1; break; end
      end
      if (!got) timeout("rsp_valid_wait");
      push_txn(1'b0, 32'h3000_0007, 8'h00, mk_plan(2'b00, 1'b0, 0, 0, 0, 0));
      @(posedge clk); #1;
      cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 32'h3000_0007; cmd_wdata_i = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("cmd_blocked", cmd_ready_o, 1'b0);
      end
      @(posedge clk); #1;
      rdy_mode = 2;
      @(negedge clk);
      chk("cmd_blocked_at_rsp_hs", cmd_ready_o, 1'b0);
      @(negedge clk);
      chk("cmd_reopen", cmd_ready_o, 1'b1);
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      drain();
      rdy_mode = 0;

      // Randomized traffic over a small address window so reads hit earlier writes.
      for (int n = 0; n < 40; n++) begin
         issue(1'($urandom_range(0, 1)), 32'h3000_0000 + 32'($urandom_range(0, 15)), 8'($urandom),
               mk_plan(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
      end
      drain();

      // Reset while the write waits for B aborts silently.
      rdy_mode = 2;
      issue(1'b1, 32'h3000_0030, 8'h5A, mk_plan(2'b00, 1'b0, 0, 0, 0, 20));
      got = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_bready_o) begin got = 1; break; end
      end
      if (!got) timeout("bready_wait");
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valids", {m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o, rsp_valid_o}, 6'b0);
      chk("abort_cmd_ready", cmd_ready_o, 1'b1);
      void'(exp_q.pop_back());
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_reset_no_rsp", rsp_valid_o, 1'b0);
         chk("post_reset_cmd_ready", cmd_ready_o, 1'b1);
      end
      rdy_mode = 0;
      issue(1'b0, 32'h3000_0030, 8'h00, mk_plan(2'b00, 1'b0, 0, 0, 1, 0));
      issue(1'b1, 32'h3000_0031, 8'hE1, mk_plan(2'b01, 1'b0, 2, 1, 0, 2));
      issue(1'b0, 32'h3000_0031, 8'h00, mk_plan(2'b00, 1'b0, 0, 0, 0, 0));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
